// File: rtl/alu_ctrl_pkg.sv
// Shared ALU opcode encodings and arbiter FSM state type.
package alu_ctrl_pkg;
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_SHR = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;
endpackage

// File: rtl/alu_4bit.sv
// Combinational 4-bit ALU; carry is add carry-out, subtract borrow, or shifted-out bit.
module alu_4bit
  import alu_ctrl_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [2:0] op,
  output logic [3:0] result,
  output logic       carry,
  output logic       zero
);
  logic [4:0] t;

  always_comb begin
    t = '0;
    case (op)
      OP_ADD:  t = {1'b0, a} + {1'b0, b};
      OP_SUB:  t = {1'b0, a} - {1'b0, b};
      OP_AND:  t = {1'b0, a & b};
      OP_OR:   t = {1'b0, a | b};
      OP_XOR:  t = {1'b0, a ^ b};
      OP_NOT:  t = {1'b0, ~a};
      OP_SHL:  t = {a, 1'b0};
      OP_SHR:  t = {a[0], 1'b0, a[3:1]};
      default: t = '0;
    endcase
  end

  assign result = t[3:0];
  assign carry  = t[4];
  assign zero   = (t[3:0] == 4'd0);
endmodule

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; on a tie the requester not granted last time wins.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       en,
  input  logic       last_grant,
  output logic [1:0] grant
);
  always_comb begin
    grant = 2'b00;
    if (en) begin
      case (req)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last_grant ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end
endmodule

// File: rtl/alu_arbiter.sv
// Shares one alu_4bit between two valid/ready requesters; one op in flight,
// result registered at the end of EXEC and held until the owner accepts it.
module alu_arbiter
  import alu_ctrl_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [3:0]       req0_a,
  input  logic [3:0]       req0_b,
  input  logic [2:0]       req0_op,
  input  logic [3:0]       req1_a,
  input  logic [3:0]       req1_b,
  input  logic [2:0]       req1_op,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [3:0]       rsp_result,
  output logic             rsp_carry,
  output logic             rsp_zero,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);
  state_t           state_q;
  logic             last_grant_q, owner_q;
  logic [3:0]       a_q, b_q, result_q;
  logic [2:0]       op_q;
  logic             carry_q, zero_q;
  logic [CNT_W-1:0] op_count_q;

  logic [1:0] grant;
  logic       hs, sel;
  logic [3:0] alu_res;
  logic       alu_c, alu_z;

  rr_arbiter2 u_arb (
    .req        (req_valid),
    .en         (state_q == ST_IDLE),
    .last_grant (last_grant_q),
    .grant      (grant)
  );

  alu_4bit u_alu (
    .a      (a_q),
    .b      (b_q),
    .op     (op_q),
    .result (alu_res),
    .carry  (alu_c),
    .zero   (alu_z)
  );

  assign hs  = |(req_valid & grant);
  assign sel = grant[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      result_q     <= '0;
      carry_q      <= 1'b0;
      zero_q       <= 1'b0;
      op_count_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (hs) begin
          state_q      <= ST_EXEC;
          owner_q      <= sel;
          last_grant_q <= sel;
          a_q          <= sel ? req1_a  : req0_a;
          b_q          <= sel ? req1_b  : req0_b;
          op_q         <= sel ? req1_op : req0_op;
        end
        ST_EXEC: begin
          result_q <= alu_res;
          carry_q  <= alu_c;
          zero_q   <= alu_z;
          state_q  <= ST_RESP;
        end
        ST_RESP: if (rsp_ready[owner_q]) begin
          state_q    <= ST_IDLE;
          op_count_q <= op_count_q + CNT_W'(1);
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Non-owner's rsp_ready is never looked at, so its bit stays low.
  assign req_ready  = grant;
  assign rsp_valid  = (state_q == ST_RESP) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_result = result_q;
  assign rsp_carry  = carry_q;
  assign rsp_zero   = zero_q;
  assign busy       = (state_q != ST_IDLE);
  assign op_count   = op_count_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter; a second instance with CNT_W=2 checks counter wrap.
module tb_alu_arbiter;
  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req_valid, rsp_ready;
  logic [3:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0] req0_op, req1_op;

  logic [1:0] req_ready, rsp_valid;
  logic [3:0] rsp_result;
  logic       rsp_carry, rsp_zero, busy;
  logic [7:0] op_count;

  logic [1:0] req_ready2, rsp_valid2;
  logic [3:0] rsp_result2;
  logic       rsp_carry2, rsp_zero2, busy2;
  logic [1:0] op_count2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_carry(rsp_carry), .rsp_zero(rsp_zero), .busy(busy), .op_count(op_count)
  );

  alu_arbiter #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready2),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready), .rsp_result(rsp_result2),
    .rsp_carry(rsp_carry2), .rsp_zero(rsp_zero2), .busy(busy2), .op_count(op_count2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) step();
    rst = 1'b0;
  endtask

  // Full requester-0 op with fixed timing; checks response and both counters.
  task automatic run_op0(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op,
                         input logic [3:0] eres, input logic ec, input logic ez,
                         input logic [7:0] ecnt, input logic [1:0] ecnt2);
    req0_a = a; req0_b = b; req0_op = op; req_valid = 2'b01;
    chk("op_rdy", req_ready, 2'b01);
    step();
    req_valid = 2'b00;
    step();
    chk("op_vld", rsp_valid, 2'b01);
    chk("op_res", {rsp_result, rsp_carry, rsp_zero}, {eres, ec, ez});
    rsp_ready = 2'b01;
    step();
    rsp_ready = 2'b00;
    chk("op_cnt", op_count, ecnt);
    chk("op_cnt2", op_count2, ecnt2);
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; rsp_ready = '0;
    req0_a = '0; req0_b = '0; req0_op = '0;
    req1_a = '0; req1_b = '0; req1_op = '0;
    do_reset(2);

    // 1: reset mid-traffic (op in RESP)
    req0_a = 4'd3; req0_b = 4'd4; req0_op = 3'b000; req_valid = 2'b01;
    step();
    req_valid = 2'b00;
    step();
    chk("pre_rst_vld", rsp_valid, 2'b01);
    do_reset(3);
    chk("rst_out", {req_ready, rsp_valid, rsp_result, rsp_carry, rsp_zero, busy}, '0);
    chk("rst_cnt", op_count, 8'd0);

    // 2: req0 ADD 7+9 = 0x10
    req0_a = 4'd7; req0_b = 4'd9; req0_op = 3'b000; req_valid = 2'b01;
    chk("add_rdy", req_ready, 2'b01);
    step();
    req_valid = 2'b00;
    chk("add_n1_vld", rsp_valid, 2'b00);
    chk("add_busy", busy, 1'b1);
    step();
    chk("add_vld", rsp_valid, 2'b01);
    chk("add_res", {rsp_result, rsp_carry, rsp_zero}, {4'd0, 1'b1, 1'b1});
    chk("add_rdy_resp", req_ready, 2'b00);
    rsp_ready = 2'b01;
    step();
    rsp_ready = 2'b00;
    chk("add_cnt", op_count, 8'd1);
    chk("add_idle", {rsp_valid, busy}, 3'b000);

    // 3: round-robin from reset
    do_reset(1);
    req0_a = 4'd5; req0_b = 4'd3; req0_op = 3'b001;
    req1_a = 4'b1001; req1_b = 4'd0; req1_op = 3'b110;
    req_valid = 2'b11;
    chk("tie1_rdy", req_ready, 2'b01);
    step();
    req_valid = 2'b10;
    step();
    chk("sub_vld", rsp_valid, 2'b01);
    chk("sub_res", {rsp_result, rsp_carry, rsp_zero}, {4'd2, 1'b0, 1'b0});
    chk("sub_block", req_ready, 2'b00);
    rsp_ready = 2'b11;
    step();
    rsp_ready = 2'b00;
    req_valid = 2'b11;
    chk("tie2_rdy", req_ready, 2'b10);
    step();
    req_valid = 2'b01;
    req0_a = 4'hA; req0_b = 4'h6; req0_op = 3'b100;
    step();
    chk("shl_vld", rsp_valid, 2'b10);
    chk("shl_res", {rsp_result, rsp_carry, rsp_zero}, {4'b0010, 1'b1, 1'b0});
    rsp_ready = 2'b01;
    step();
    chk("ignore_nonowner", rsp_valid, 2'b10);
    rsp_ready = 2'b10;
    step();
    rsp_ready = 2'b00;
    req_valid = 2'b11;
    chk("tie3_rdy", req_ready, 2'b01);

    // 4: XOR A^6 = C, response held with rsp_ready low
    step();
    req_valid = 2'b10;
    step();
    for (int i = 0; i < 5; i++) begin
      chk("hold_vld", rsp_valid, 2'b01);
      chk("hold_res", {rsp_result, rsp_carry, rsp_zero}, {4'hC, 1'b0, 1'b0});
      chk("hold_rdy", {req_ready, busy}, 3'b001);
      chk("hold_cnt", op_count, 8'd2);
      step();
    end
    req_valid = 2'b00;
    rsp_ready = 2'b01;
    step();
    rsp_ready = 2'b00;
    chk("hold_done_cnt", op_count, 8'd3);

    // 5: reset during EXEC aborts the op
    req0_a = 4'd1; req0_b = 4'd1; req0_op = 3'b000; req_valid = 2'b01;
    step();
    req_valid = 2'b00;
    chk("abort_exec", busy, 1'b1);
    do_reset(1);
    for (int i = 0; i < 4; i++) begin
      chk("abort_vld", rsp_valid, 2'b00);
      rsp_ready = 2'b11;
      step();
    end
    rsp_ready = 2'b00;
    req0_a = 4'd3; req0_b = 4'd4; req0_op = 3'b011;
    req1_a = 4'd0; req1_b = 4'd0; req1_op = 3'b000;
    req_valid = 2'b11;
    chk("post_abort_rdy", req_ready, 2'b01);
    step();
    req_valid = 2'b00;
    step();
    chk("or_vld", rsp_valid, 2'b01);
    chk("or_res", {rsp_result, rsp_carry, rsp_zero}, {4'd7, 1'b0, 1'b0});
    rsp_ready = 2'b01;
    step();
    rsp_ready = 2'b00;
    chk("or_cnt", op_count, 8'd1);

    // 6: counter wrap on the CNT_W=2 instance
    do_reset(1);
    run_op0(4'hC, 4'hA, 3'b010, 4'h8, 1'b0, 1'b0, 8'd1, 2'd1);
    run_op0(4'b1001, 4'h0, 3'b111, 4'b0100, 1'b1, 1'b0, 8'd2, 2'd2);
    run_op0(4'hF, 4'h0, 3'b101, 4'h0, 1'b0, 1'b1, 8'd3, 2'd3);
    run_op0(4'd2, 4'd3, 3'b001, 4'hF, 1'b1, 1'b0, 8'd4, 2'd0);
    run_op0(4'h5, 4'h5, 3'b100, 4'h0, 1'b0, 1'b1, 8'd5, 2'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
